// File: rtl/map_table_recovery_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | map_table_recovery_ctrl: checkpoint restore / ROB walk-back recovery FSM |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module map_table_recovery_ctrl #(
  parameter int ROB_INDEX_W = 4,
  parameter int CKPT_COL_W  = 2,
  parameter int ARCH_TAG_W  = 5,
  parameter int PHYS_TAG_W  = 6
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   rec_req_valid,
  output logic                   rec_req_ready,
  input  logic [ROB_INDEX_W-1:0] rec_req_ROB_index,
  input  logic                   rec_req_use_checkpoint,
  input  logic [CKPT_COL_W-1:0]  rec_req_column,
  input  logic [ROB_INDEX_W-1:0] rob_tail_index,
  output logic [ROB_INDEX_W-1:0] rob_read_index,
  input  logic                   rob_read_has_dest,
  input  logic [ARCH_TAG_W-1:0]  rob_read_dest_arch_reg_tag,
  input  logic [PHYS_TAG_W-1:0]  rob_read_safe_phys_reg_tag,
  input  logic [PHYS_TAG_W-1:0]  rob_read_speculated_phys_reg_tag,
  input  logic                   resolve_valid,
  input  logic [ROB_INDEX_W-1:0] resolve_ROB_index,
  input  logic [CKPT_COL_W-1:0]  resolve_column,
  output logic                   resolve_ready,
  output logic                   revert_valid,
  output logic [ARCH_TAG_W-1:0]  revert_dest_arch_reg_tag,
  output logic [PHYS_TAG_W-1:0]  revert_safe_dest_phys_reg_tag,
  output logic [PHYS_TAG_W-1:0]  revert_speculated_dest_phys_reg_tag,
  output logic                   restore_checkpoint_valid,
  output logic                   restore_checkpoint_speculate_failed,
  output logic [ROB_INDEX_W-1:0] restore_checkpoint_ROB_index,
  output logic [CKPT_COL_W-1:0]  restore_checkpoint_safe_column,
  input  logic                   restore_checkpoint_success,
  output logic                   dispatch_stall,
  output logic                   rob_rollback_valid,
  output logic [ROB_INDEX_W-1:0] rob_rollback_tail_index,
  output logic                   recovery_done
);

  localparam logic [ROB_INDEX_W-1:0] IDX_ONE = ROB_INDEX_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    WALK    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ROB_INDEX_W-1:0] saved_index_q, saved_index_d;
  logic [CKPT_COL_W-1:0]  saved_column_q, saved_column_d;
  logic [ROB_INDEX_W-1:0] walk_ptr_q, walk_ptr_d;
  logic                   resolve_fire;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= IDLE;
      saved_index_q  <= '0;
      saved_column_q <= '0;
      walk_ptr_q     <= '0;
    end else begin
      state_q        <= state_d;
      saved_index_q  <= saved_index_d;
      saved_column_q <= saved_column_d;
      walk_ptr_q     <= walk_ptr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    saved_index_d  = saved_index_q;
    saved_column_d = saved_column_q;
    walk_ptr_d     = walk_ptr_q;

    rec_req_ready                       = (state_q == IDLE);
    resolve_ready                       = (state_q != RESTORE);
    dispatch_stall                      = (state_q != IDLE) | rec_req_valid;
    rob_read_index                      = '0;
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = '0;
    revert_safe_dest_phys_reg_tag       = '0;
    revert_speculated_dest_phys_reg_tag = '0;
    restore_checkpoint_valid            = 1'b0;
    restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_ROB_index        = '0;
    restore_checkpoint_safe_column      = '0;
    rob_rollback_valid                  = 1'b0;
    rob_rollback_tail_index             = '0;
    recovery_done                       = 1'b0;

    // Resolve frees are blocked while in reset so every output except the
    // ready/stall signals stays low.
    resolve_fire = resolve_valid & resolve_ready & nRST;
    if (resolve_fire) begin
      restore_checkpoint_valid       = 1'b1;
      restore_checkpoint_ROB_index   = resolve_ROB_index;
      restore_checkpoint_safe_column = resolve_column;
    end

    case (state_q)
      IDLE: begin
        if (rec_req_valid) begin
          saved_index_d  = rec_req_ROB_index;
          saved_column_d = rec_req_column;
          if (rec_req_use_checkpoint) begin
            state_d = RESTORE;
          end else begin
            state_d    = WALK;
            walk_ptr_d = rob_tail_index - IDX_ONE;
          end
        end
      end
      RESTORE: begin
        restore_checkpoint_valid            = 1'b1;
        restore_checkpoint_speculate_failed = 1'b1;
        restore_checkpoint_ROB_index        = saved_index_q;
        restore_checkpoint_safe_column      = saved_column_q;
        if (restore_checkpoint_success) begin
          state_d = DONE;
        end else begin
          state_d    = WALK;
          walk_ptr_d = rob_tail_index - IDX_ONE;
        end
      end
      WALK: begin
        rob_read_index = walk_ptr_q;
        // The surviving instruction itself is never reverted.
        if (walk_ptr_q == saved_index_q) begin
          state_d = DONE;
        end else begin
          revert_valid = rob_read_has_dest;
          if (rob_read_has_dest) begin
            revert_dest_arch_reg_tag            = rob_read_dest_arch_reg_tag;
            revert_safe_dest_phys_reg_tag       = rob_read_safe_phys_reg_tag;
            revert_speculated_dest_phys_reg_tag = rob_read_speculated_phys_reg_tag;
          end
          walk_ptr_d = walk_ptr_q - IDX_ONE;
        end
      end
      DONE: begin
        recovery_done           = 1'b1;
        rob_rollback_valid      = 1'b1;
        rob_rollback_tail_index = saved_index_q + IDX_ONE;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_map_table_recovery_ctrl.sv
`default_nettype none
// Directed bench for map_table_recovery_ctrl with a small combinational ROB model.
module tb_map_table_recovery_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       rec_req_valid, rec_req_use_checkpoint;
  logic       rec_req_ready;
  logic [3:0] rec_req_ROB_index, rob_tail_index, rob_read_index;
  logic [1:0] rec_req_column, resolve_column, restore_checkpoint_safe_column;
  logic       rob_read_has_dest;
  logic [4:0] rob_read_dest_arch_reg_tag, revert_dest_arch_reg_tag;
  logic [5:0] rob_read_safe_phys_reg_tag, rob_read_speculated_phys_reg_tag;
  logic [5:0] revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag;
  logic       resolve_valid, resolve_ready, revert_valid;
  logic [3:0] resolve_ROB_index, restore_checkpoint_ROB_index, rob_rollback_tail_index;
  logic       restore_checkpoint_valid, restore_checkpoint_speculate_failed;
  logic       restore_checkpoint_success;
  logic       dispatch_stall, rob_rollback_valid, recovery_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  // ROB contents: entry i has a destination unless i is a multiple of 3;
  // arch tag i+1, safe phys i+16, speculated phys i+32.
  always_comb begin
    rob_read_has_dest                = (rob_read_index % 3) != 0;
    rob_read_dest_arch_reg_tag       = 5'(rob_read_index + 1);
    rob_read_safe_phys_reg_tag       = 6'(rob_read_index + 16);
    rob_read_speculated_phys_reg_tag = 6'(rob_read_index + 32);
  end

  map_table_recovery_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .rec_req_valid(rec_req_valid), .rec_req_ready(rec_req_ready),
    .rec_req_ROB_index(rec_req_ROB_index), .rec_req_use_checkpoint(rec_req_use_checkpoint),
    .rec_req_column(rec_req_column), .rob_tail_index(rob_tail_index),
    .rob_read_index(rob_read_index), .rob_read_has_dest(rob_read_has_dest),
    .rob_read_dest_arch_reg_tag(rob_read_dest_arch_reg_tag),
    .rob_read_safe_phys_reg_tag(rob_read_safe_phys_reg_tag),
    .rob_read_speculated_phys_reg_tag(rob_read_speculated_phys_reg_tag),
    .resolve_valid(resolve_valid), .resolve_ROB_index(resolve_ROB_index),
    .resolve_column(resolve_column), .resolve_ready(resolve_ready),
    .revert_valid(revert_valid), .revert_dest_arch_reg_tag(revert_dest_arch_reg_tag),
    .revert_safe_dest_phys_reg_tag(revert_safe_dest_phys_reg_tag),
    .revert_speculated_dest_phys_reg_tag(revert_speculated_dest_phys_reg_tag),
    .restore_checkpoint_valid(restore_checkpoint_valid),
    .restore_checkpoint_speculate_failed(restore_checkpoint_speculate_failed),
    .restore_checkpoint_ROB_index(restore_checkpoint_ROB_index),
    .restore_checkpoint_safe_column(restore_checkpoint_safe_column),
    .restore_checkpoint_success(restore_checkpoint_success),
    .dispatch_stall(dispatch_stall), .rob_rollback_valid(rob_rollback_valid),
    .rob_rollback_tail_index(rob_rollback_tail_index), .recovery_done(recovery_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs checked mid-cycle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_walk(input string tag, input logic [3:0] idx, input logic rv,
                            input logic [4:0] arch, input logic [5:0] safe, input logic [5:0] spec);
    #1;
    check({tag, "_rd"},   rob_read_index, idx);
    check({tag, "_rv"},   revert_valid, rv);
    check({tag, "_arch"}, revert_dest_arch_reg_tag, arch);
    check({tag, "_safe"}, revert_safe_dest_phys_reg_tag, safe);
    check({tag, "_spec"}, revert_speculated_dest_phys_reg_tag, spec);
  endtask

  task automatic check_done(input string tag, input logic [3:0] tail);
    #1;
    check({tag, "_done"}, recovery_done, 1'b1);
    check({tag, "_rbv"},  rob_rollback_valid, 1'b1);
    check({tag, "_rbt"},  rob_rollback_tail_index, tail);
    check({tag, "_rv"},   revert_valid, 1'b0);
  endtask

  task automatic request(input logic [3:0] idx, input logic ck, input logic [1:0] col,
                         input logic [3:0] tail);
    rec_req_valid = 1'b1; rec_req_ROB_index = idx; rec_req_use_checkpoint = ck;
    rec_req_column = col; rob_tail_index = tail;
    #1;
    check("req_ready", rec_req_ready, 1'b1);
    check("req_stall", dispatch_stall, 1'b1);
    step();
    rec_req_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; rec_req_valid = 1'b0; rec_req_use_checkpoint = 1'b0;
    rec_req_ROB_index = '0; rec_req_column = '0; rob_tail_index = '0;
    resolve_valid = 1'b0; resolve_ROB_index = '0; resolve_column = '0;
    restore_checkpoint_success = 1'b0;
    #12;
    // Reset-state outputs, including a pending request and resolve.
    rec_req_valid = 1'b1; resolve_valid = 1'b1;
    #1;
    check("rst_req_ready", rec_req_ready, 1'b1);
    check("rst_res_ready", resolve_ready, 1'b1);
    check("rst_stall", dispatch_stall, 1'b1);
    check("rst_restore", restore_checkpoint_valid, 1'b0);
    check("rst_done", recovery_done, 1'b0);
    rec_req_valid = 1'b0; resolve_valid = 1'b0;
    #1;
    check("rst_stall0", dispatch_stall, 1'b0);
    nRST = 1'b1;
    step();

    // Resolve in IDLE issues an invalidate.
    resolve_valid = 1'b1; resolve_ROB_index = 4'd4; resolve_column = 2'd2;
    #1;
    check("idle_res_v", restore_checkpoint_valid, 1'b1);
    check("idle_res_f", restore_checkpoint_speculate_failed, 1'b0);
    check("idle_res_i", restore_checkpoint_ROB_index, 4'd4);
    check("idle_res_c", restore_checkpoint_safe_column, 2'd2);
    resolve_valid = 1'b0;
    step();

    // Checkpoint hit; resolve held off in RESTORE, issued in DONE.
    request(4'd5, 1'b1, 2'd2, 4'd9);
    restore_checkpoint_success = 1'b1;
    resolve_valid = 1'b1; resolve_ROB_index = 4'd3; resolve_column = 2'd1;
    #1;
    check("hit_rs_v", restore_checkpoint_valid, 1'b1);
    check("hit_rs_f", restore_checkpoint_speculate_failed, 1'b1);
    check("hit_rs_i", restore_checkpoint_ROB_index, 4'd5);
    check("hit_rs_c", restore_checkpoint_safe_column, 2'd2);
    check("hit_res_rdy", resolve_ready, 1'b0);
    check("hit_req_rdy", rec_req_ready, 1'b0);
    step();
    restore_checkpoint_success = 1'b0;
    check_done("hit", 4'd6);
    check("hit_dn_res_v", restore_checkpoint_valid, 1'b1);
    check("hit_dn_res_f", restore_checkpoint_speculate_failed, 1'b0);
    check("hit_dn_res_i", restore_checkpoint_ROB_index, 4'd3);
    resolve_valid = 1'b0;
    step();
    #1;
    check("hit_idle_done", recovery_done, 1'b0);
    check("hit_idle_stall", dispatch_stall, 1'b0);

    // Checkpoint miss falls back to a walk 8,7,6 then stop at 5.
    request(4'd5, 1'b1, 2'd1, 4'd9);
    restore_checkpoint_success = 1'b0;
    #1;
    check("miss_rs_f", restore_checkpoint_speculate_failed, 1'b1);
    step();
    resolve_valid = 1'b1; resolve_ROB_index = 4'd2; resolve_column = 2'd3;
    check_walk("miss8", 4'd8, 1'b1, 5'd9, 6'd24, 6'd40);
    check("miss8_res_v", restore_checkpoint_valid, 1'b1);
    check("miss8_res_f", restore_checkpoint_speculate_failed, 1'b0);
    check("miss8_res_c", restore_checkpoint_safe_column, 2'd3);
    resolve_valid = 1'b0;
    step(); check_walk("miss7", 4'd7, 1'b1, 5'd8, 6'd23, 6'd39);
    step(); check_walk("miss6", 4'd6, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_walk("miss5", 4'd5, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_done("miss", 4'd6);
    step();

    // Wrap-around walk: 1,0,15 then stop at 14.
    request(4'd14, 1'b0, 2'd0, 4'd2);
    check_walk("wrap1", 4'd1, 1'b1, 5'd2, 6'd17, 6'd33);
    step(); check_walk("wrap0", 4'd0, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_walk("wrap15", 4'd15, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_walk("wrap14", 4'd14, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_done("wrap", 4'd15);
    step();

    // Empty walk: single WALK cycle.
    request(4'd7, 1'b0, 2'd0, 4'd8);
    check_walk("empty7", 4'd7, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_done("empty", 4'd8);
    step();

    // Asynchronous reset in the middle of a walk.
    request(4'd5, 1'b0, 2'd0, 4'd12);
    check_walk("rw11", 4'd11, 1'b1, 5'd12, 6'd27, 6'd43);
    step(); check_walk("rw10", 4'd10, 1'b1, 5'd11, 6'd26, 6'd42);
    #1;
    nRST = 1'b0;
    #1;
    check("rw_rst_rd", rob_read_index, 4'd0);
    check("rw_rst_rv", revert_valid, 1'b0);
    check("rw_rst_stall", dispatch_stall, 1'b0);
    check("rw_rst_ready", rec_req_ready, 1'b1);
    step();
    nRST = 1'b1;
    step();
    #1;
    check("rw_idle_ready", rec_req_ready, 1'b1);
    request(4'd7, 1'b0, 2'd0, 4'd8);
    check_walk("rw_e7", 4'd7, 1'b0, 5'd0, 6'd0, 6'd0);
    step(); check_done("rw_e", 4'd8);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/map_table_recovery_ctrl.md
MAP_TABLE_RECOVERY_CTRL -- requirements
Module: map_table_recovery_ctrl

Interface
REQ-001 SHALL use parameter ROB_index_t/checkpoint_column_t/arch_reg_tag_t/phys_reg_tag_t widths from core_types_pkg; ROB depth a power of two, natural-width wrap.
REQ-002 SHALL have ports (name dir width meaning):
- CLK in 1 clock; nRST in 1 reset, asynchronous, active-low
- rec_req_valid in 1 mispredict/exception recovery request; rec_req_ready out 1 request accepted
- rec_req_ROB_index in ROB_index_t oldest surviving instr; rec_req_use_checkpoint in 1 instr owns checkpoint; rec_req_column in checkpoint_column_t its column
- rob_tail_index in ROB_index_t next ROB alloc slot
- rob_read_index out ROB_index_t walk read addr; rob_read_has_dest in 1; rob_read_dest_arch_reg_tag in arch_reg_tag_t; rob_read_safe_phys_reg_tag in phys_reg_tag_t; rob_read_speculated_phys_reg_tag in phys_reg_tag_t (combinational same-cycle read)
- resolve_valid in 1 correct-branch checkpoint free; resolve_ROB_index in ROB_index_t; resolve_column in checkpoint_column_t; resolve_ready out 1
- revert_valid, revert_dest_arch_reg_tag, revert_safe_dest_phys_reg_tag, revert_speculated_dest_phys_reg_tag out to map table
- restore_checkpoint_valid out 1; restore_checkpoint_speculate_failed out 1; restore_checkpoint_ROB_index out ROB_index_t; restore_checkpoint_safe_column out checkpoint_column_t; restore_checkpoint_success in 1
- dispatch_stall out 1; rob_rollback_valid out 1 pulse; rob_rollback_tail_index out ROB_index_t; recovery_done out 1 pulse

Function
REQ-003 SHALL implement FSM IDLE, RESTORE, WALK, DONE; registers: state, saved ROB index, saved column, walk_ptr.
REQ-004 rec_req_ready SHALL equal (state==IDLE); accept = rec_req_valid & rec_req_ready, capturing index/column.
REQ-005 On accept: use_checkpoint=1 -> RESTORE; else -> WALK, walk_ptr = rob_tail_index-1.
REQ-006 RESTORE: restore_checkpoint_valid=1, speculate_failed=1, ROB_index/column = saved values; success=1 -> DONE; success=0 -> WALK, walk_ptr = rob_tail_index-1.
REQ-007 WALK: rob_read_index=walk_ptr; if walk_ptr==saved index -> DONE, no revert that cycle; else revert_valid=rob_read_has_dest with ROB fields forwarded, walk_ptr decrements (wraps 0 -> max).
REQ-008 Walk with no younger entries (tail-1==saved index) SHALL spend exactly one WALK cycle, zero reverts.
REQ-009 DONE: one cycle, recovery_done=1, rob_rollback_valid=1, rob_rollback_tail_index=saved index+1 (wrapping); -> IDLE.
REQ-010 dispatch_stall SHALL = (state!=IDLE) | rec_req_valid.
REQ-011 resolve_ready SHALL = (state!=RESTORE); when resolve_valid & resolve_ready, restore_checkpoint_valid=1, speculate_failed=0, ROB_index/column = resolve fields; legal concurrent with revert_valid.
REQ-012 In RESTORE, resolve SHALL be held off (resolve_ready=0); requester keeps resolve_valid asserted.
REQ-013 restore_checkpoint_success SHALL be consumed only in RESTORE; ignored otherwise.
REQ-014 Latency: checkpoint hit = accept cycle 0, RESTORE 1, DONE 2, IDLE 3; walk of N younger entries = N+1 WALK cycles then DONE.
REQ-015 All unused outputs SHALL drive 0 in every state.

Reset
REQ-016 nRST low SHALL force IDLE, saved regs/walk_ptr 0, immediately (asynchronous), including mid-RESTORE/WALK.
REQ-017 In reset: all outputs 0 except rec_req_ready=1, resolve_ready=1; dispatch_stall=rec_req_valid.

Verification
REQ-018 Req idx=5, use_ckpt=1, col=2, success=1 -> restore pulse cycle 1 (failed=1, idx 5, col 2), done+rollback tail=6 cycle 2, no reverts.
REQ-019 Req idx=5, use_ckpt=1, success=0, tail=9 -> RESTORE then reads 8,7,6, reverts for has_dest entries, DONE tail=6.
REQ-020 Wrap: ROB depth 16, idx=14, tail=2 -> reads 1,0,15, stop at 14, rollback tail=15.
REQ-021 Empty walk: idx=7, tail=8, use_ckpt=0 -> one WALK cycle, zero reverts, DONE tail=8.
REQ-022 resolve_valid during RESTORE -> resolve_ready=0 until DONE, then invalidate (failed=0) issued; resolve during WALK issued same cycle as revert.
REQ-023 nRST asserted mid-WALK -> outputs zero at once, IDLE after release, next request handled normally.
